day05_input_writer: RTL and testbench

- Formats binary range and ID records into the ASCII byte stream that the day05 core consumes from ROM: "L-R\n" lines, one blank line, then "ID\n" lines.
- Writes one byte per cycle into a byte-wide memory write port.
- Used by the testbench and the on-chip self-test to build input images from binary records.
- Decimal conversion is done sequentially with a double-dabble sub-module.

---
 rtl/day05_pkg.sv | 50 +++++
 rtl/day05_bin2bcd.sv | 55 +++++
 rtl/day05_input_writer.sv | 211 +++++++++++++++++++++
 tb/tb_day05_input_writer.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/day05_pkg.sv
// Shared definitions for the day05 input writer: record kinds, ASCII bytes,
// writer states, and BCD helpers used by the double-dabble converter.
package day05_pkg;

   // Record kind encodings on in_kind
   localparam logic [1:0] KIND_RANGE = 2'd0;
   localparam logic [1:0] KIND_SEP   = 2'd1;
   localparam logic [1:0] KIND_VALUE = 2'd2;
   localparam logic [1:0] KIND_END   = 2'd3;

   // ASCII bytes written into the stream
   localparam logic [7:0] CH_ZERO = 8'h30;
   localparam logic [7:0] CH_DASH = 8'h2D;
   localparam logic [7:0] CH_NL   = 8'h0A;

   // A 64-bit unsigned value never needs more than 20 decimal digits
   localparam int BCD_DIGITS = 20;
   localparam int BCD_BITS   = 4 * BCD_DIGITS;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CONV,
      S_EMIT,
      S_DASH,
      S_NL,
      S_DONE
   } wr_state_e;

   // Index of the most significant non-zero digit; 0 when the value is 0,
   // so a zero operand still emits exactly one "0".
   function automatic logic [4:0] lead_digit(input logic [BCD_BITS-1:0] bcd);
      logic [4:0] l;
      l = '0;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (bcd[4*i +: 4] != 4'd0) l = 5'(i);
      end
      return l;
   endfunction

   // Double-dabble correction: every digit >= 5 gets +3 before the shift.
   function automatic logic [BCD_BITS-1:0] bcd_adjust(input logic [BCD_BITS-1:0] bcd);
      logic [BCD_BITS-1:0] r;
      r = bcd;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

endpackage

// File: rtl/day05_bin2bcd.sv
// Sequential 64-bit binary to 20-digit BCD converter (double-dabble).
// The start cycle loads the operand and performs the first shift; 63 more
// shifts follow, one per cycle, and done pulses for one cycle once bcd holds
// the final result.
module day05_bin2bcd
   import day05_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [63:0]         bin,
   output logic                busy,
   output logic                done,
   output logic [BCD_BITS-1:0] bcd
);

   logic [63:0]         sh;
   logic [5:0]          cnt;
   logic [BCD_BITS-1:0] bcd_adj;

   // Per-digit +3 correction applied ahead of each shift
   always_comb begin
      bcd_adj = bcd_adjust(bcd);
   end

   // Shift engine: load-and-first-shift on start, then 63 correction/shift steps
   always_ff @(posedge clk) begin
      if (rst) begin
         sh   <= '0;
         cnt  <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         bcd  <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            // An all-zero BCD register needs no correction, so the first
            // shift can be folded into the load.
            bcd  <= {{(BCD_BITS-1){1'b0}}, bin[63]};
            sh   <= {bin[62:0], 1'b0};
            cnt  <= 6'd1;
            busy <= 1'b1;
         end else if (busy) begin
            bcd <= {bcd_adj[BCD_BITS-2:0], sh[63]};
            sh  <= {sh[62:0], 1'b0};
            cnt <= cnt + 6'd1;
            if (cnt == 6'd63) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/day05_input_writer.sv
// Formats binary RANGE / SEP / VALUE / END records into the ASCII image the
// day05 core reads from ROM ("L-R\n" lines, a blank line, "ID\n" lines),
// writing one byte per cycle. Decimal digits come from day05_bin2bcd.
// Optional build macro DAY05_WR_NO_FINAL_NL_EN: when the last record written
// was a VALUE, byte_count excludes its trailing newline (the byte is still
// written), so the core sees EOF with a pending digit string.
//
// Handshake: a record is taken on the rising edge where in_valid && in_ready;
// in_ready is high only while idle, and the record fields are captured on that
// edge so the source may change them immediately afterwards.
module day05_input_writer
   import day05_pkg::*;
#(
   parameter int N_ADDR_BITS = 16,
   parameter int MEM_DEPTH   = 65536
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [1:0]             in_kind,
   input  logic [63:0]            in_lo,
   input  logic [63:0]            in_hi,
   output logic                   mem_we,
   output logic [N_ADDR_BITS:0]   mem_addr,
   output logic [7:0]             mem_wdata,
   output logic [N_ADDR_BITS:0]   byte_count,
   output logic                   done,
   output logic                   overflow,
   output logic                   proto_err
);

   localparam int AW = N_ADDR_BITS + 1;

   wr_state_e           state;
   logic [1:0]          kind_r;
   logic [63:0]         lo_r;
   logic [63:0]         hi_r;
   logic                phase;      // 0: first operand (lo), 1: second operand (hi)
   logic [4:0]          pos;        // digit currently on the write port during EMIT
   logic                sep_seen;
   logic [AW-1:0]       ptr;

   logic                b2b_start;
   logic                b2b_busy;
   logic                b2b_done;
   logic [BCD_BITS-1:0] b2b_bcd;
   logic [63:0]         b2b_bin;

   logic                accept;
   logic                legal;
   logic [4:0]          lead;
   logic [4:0]          emit_idx;
   logic [3:0]          digit;
   logic                wr_go;
   logic [7:0]          wr_byte;
   logic                in_range;
   logic [AW-1:0]       final_count;

   assign in_ready = (state == S_IDLE) && !rst && !b2b_busy;
   assign accept   = in_valid && in_ready;
   assign b2b_bin  = phase ? hi_r : lo_r;
   assign in_range = 32'(ptr) < MEM_DEPTH;
   assign lead     = lead_digit(b2b_bcd);
   assign emit_idx = (state == S_CONV) ? lead : pos - 5'd1;
   assign digit    = b2b_bcd[{emit_idx, 2'b00} +: 4];

   day05_bin2bcd u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (b2b_start),
      .bin   (b2b_bin),
      .busy  (b2b_busy),
      .done  (b2b_done),
      .bcd   (b2b_bcd)
   );

   // Record legality: ranges and the separator only before the blank line, IDs only after
   always_comb begin
      legal = 1'b1;
      case (in_kind)
         KIND_VALUE: legal = sep_seen;
         KIND_END:   legal = 1'b1;
         default:    legal = !sep_seen;
      endcase
   end

   // Byte scheduled for the next cycle: each state's byte is registered on entry
   always_comb begin
      wr_go   = 1'b0;
      wr_byte = CH_NL;
      case (state)
         S_IDLE: begin
            if (accept && legal && in_kind == KIND_SEP) wr_go = 1'b1;
         end
         S_CONV: begin
            if (b2b_done) begin
               wr_go   = 1'b1;
               wr_byte = CH_ZERO + {4'd0, digit};
            end
         end
         S_EMIT: begin
            wr_go = 1'b1;
            if (pos != 5'd0)                            wr_byte = CH_ZERO + {4'd0, digit};
            else if (kind_r == KIND_RANGE && !phase)    wr_byte = CH_DASH;
            else                                        wr_byte = CH_NL;
         end
         default: ;
      endcase
   end

`ifdef DAY05_WR_NO_FINAL_NL_EN
   logic last_value;

   // Remember whether the most recent record that wrote bytes was a VALUE
   always_ff @(posedge clk) begin
      if (rst)                                                  last_value <= 1'b0;
      else if (accept && legal && in_kind != KIND_END)          last_value <= (in_kind == KIND_VALUE);
   end

   assign final_count = last_value ? ptr - AW'(1) : ptr;
`else
   assign final_count = ptr;
`endif

   // Writer FSM with registered write port and sticky status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         kind_r     <= KIND_RANGE;
         lo_r       <= '0;
         hi_r       <= '0;
         phase      <= 1'b0;
         pos        <= '0;
         sep_seen   <= 1'b0;
         ptr        <= '0;
         b2b_start  <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         byte_count <= '0;
         done       <= 1'b0;
         overflow   <= 1'b0;
         proto_err  <= 1'b0;
      end else begin
         mem_we    <= 1'b0;
         b2b_start <= 1'b0;

         // The pointer advances even for suppressed bytes so the stream
         // layout stays identical whatever the memory size.
         if (wr_go) begin
            mem_we    <= in_range;
            mem_addr  <= ptr;
            mem_wdata <= wr_byte;
            ptr       <= ptr + AW'(1);
            if (!in_range) overflow <= 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (accept) begin
                  kind_r <= in_kind;
                  lo_r   <= in_lo;
                  hi_r   <= in_hi;
                  phase  <= 1'b0;
                  if (!legal) begin
                     proto_err <= 1'b1;
                  end else begin
                     case (in_kind)
                        KIND_RANGE, KIND_VALUE: begin
                           state     <= S_CONV;
                           b2b_start <= 1'b1;
                        end
                        KIND_SEP: begin
                           state    <= S_NL;
                           sep_seen <= 1'b1;
                        end
                        default: begin
                           state      <= S_DONE;
                           done       <= 1'b1;
                           byte_count <= final_count;
                        end
                     endcase
                  end
               end
            end
            S_CONV: begin
               if (b2b_done) begin
                  state <= S_EMIT;
                  pos   <= lead;
               end
            end
            S_EMIT: begin
               if (pos != 5'd0)                          pos   <= pos - 5'd1;
               else if (kind_r == KIND_RANGE && !phase)  state <= S_DASH;
               else                                      state <= S_NL;
            end
            S_DASH: begin
               state     <= S_CONV;
               phase     <= 1'b1;
               b2b_start <= 1'b1;
            end
            S_NL: begin
               state <= S_IDLE;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_day05_input_writer.sv
// Bench for day05_input_writer: directed stream cases, illegal records,
// digit timing, reset during EMIT, a 200-record randomized run checked
// against a string-formatting reference model, and a 4-byte memory instance.
module tb_day05_input_writer;
   import day05_pkg::*;

   localparam int AW = 17;
`ifdef DAY05_WR_NO_FINAL_NL_EN
   localparam int NO_FINAL_NL = 1;
`else
   localparam int NO_FINAL_NL = 0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- main DUT ----------------
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [1:0]    in_kind = '0;
   logic [63:0]   in_lo = '0;
   logic [63:0]   in_hi = '0;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic [AW-1:0] byte_count;
   logic          done;
   logic          overflow;
   logic          proto_err;

   day05_input_writer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_kind(in_kind), .in_lo(in_lo), .in_hi(in_hi),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .byte_count(byte_count), .done(done), .overflow(overflow), .proto_err(proto_err)
   );

   // ---------------- small-memory DUT ----------------
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [1:0]    s_kind = '0;
   logic [63:0]   s_lo = '0;
   logic [63:0]   s_hi = '0;
   logic          s_we;
   logic [AW-1:0] s_addr;
   logic [7:0]    s_wdata;
   logic [AW-1:0] s_byte_count;
   logic          s_done;
   logic          s_overflow;
   logic          s_proto_err;

   day05_input_writer #(.MEM_DEPTH(4)) dut_small (
      .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_ready),
      .in_kind(s_kind), .in_lo(s_lo), .in_hi(s_hi),
      .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata),
      .byte_count(s_byte_count), .done(s_done), .overflow(s_overflow), .proto_err(s_proto_err)
   );

   // ---------------- scoreboard / model state ----------------
   int checks = 0;
   int errors = 0;
   logic [AW+7:0] exp_q[$];     // {addr, byte}
   logic [AW+7:0] s_obs[$];
   int  wr_seen = 0;
   bit  arm = 1'b0;
   int  arm_t = 0;

   bit  m_sep;
   int  m_ptr;
   bit  m_last_value;
   bit  m_proto;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_sep = 1'b0;
      m_ptr = 0;
      m_last_value = 1'b0;
      m_proto = 1'b0;
      exp_q.delete();
   endtask

   task automatic push_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         if (m_ptr < 65536) exp_q.push_back({AW'(m_ptr), 8'(s[i])});
         m_ptr++;
      end
   endtask

   // Reference: the stream is simply the decimal text of each legal record
   task automatic model_rec(input logic [1:0] kind, input logic [63:0] lo, input logic [63:0] hi);
      bit ok;
      ok = (kind == KIND_VALUE) ? m_sep : (kind == KIND_END) ? 1'b1 : !m_sep;
      if (!ok) begin
         m_proto = 1'b1;
         return;
      end
      case (kind)
         KIND_RANGE: begin push_str($sformatf("%0d-%0d\n", lo, hi)); m_last_value = 1'b0; end
         KIND_SEP:   begin push_str("\n"); m_sep = 1'b1; m_last_value = 1'b0; end
         KIND_VALUE: begin push_str($sformatf("%0d\n", lo)); m_last_value = 1'b1; end
         default: ;
      endcase
   endtask

   function automatic int model_count();
      return m_ptr - ((NO_FINAL_NL != 0 && m_last_value) ? 1 : 0);
   endfunction

   // ---------------- monitors ----------------
   // Pops one expected byte per observed write
   always @(negedge clk) begin
      logic [AW+7:0] e;
      if (!rst && mem_we) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write addr=%0d data=%02h", mem_addr, mem_wdata);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", 64'(mem_addr), 64'(e[AW+7:8]));
            check("wr_data", 64'(mem_wdata), 64'(e[7:0]));
         end
         wr_seen++;
         if (arm) begin
            arm = 1'b0;
            // cycle numbering: the cycle after edge k is cycle k+1
            check("first_digit_cycle", 64'(cyc + 1 - arm_t), 64'd66);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && s_we) s_obs.push_back({s_addr, s_wdata});
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      s_valid = 1'b0;
      repeat (3) @(negedge clk);
      model_reset();
      check("rst_in_ready", 64'(in_ready), 0);
      check("rst_mem_we", 64'(mem_we), 0);
      check("rst_done", 64'(done), 0);
      check("rst_byte_count", 64'(byte_count), 0);
      check("rst_flags", 64'({overflow, proto_err}), 0);
      rst = 1'b0;
      #1;
      check("ready_after_rst", 64'(in_ready), 1);
   endtask

   task automatic send_rec(input logic [1:0] kind, input logic [63:0] lo, input logic [63:0] hi,
                           output int acc_cyc);
      int n;
      acc_cyc = 0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      in_valid = 1'b1;
      in_kind  = kind;
      in_lo    = lo;
      in_hi    = hi;
      n = 0;
      while (!in_ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("accept_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      model_rec(kind, lo, hi);
      in_valid = 1'b0;
      in_kind  = 2'($urandom);
      in_lo    = {$urandom, $urandom};
      in_hi    = {$urandom, $urandom};
   endtask

   task automatic wait_idle(input int bound);
      int n;
      n = 0;
      while (!in_ready && n < bound) begin
         @(negedge clk);
         n++;
      end
      check("idle_wait", 64'(in_ready), 1);
   endtask

   task automatic wait_done(input int bound);
      int n;
      n = 0;
      while (!done && n < bound) begin
         @(negedge clk);
         n++;
      end
      check("done_wait", 64'(done), 1);
   endtask

   function automatic logic [63:0] rand_val();
      case ($urandom_range(0, 5))
         0, 1, 2: return 64'($urandom_range(0, 999));
         3:       return {$urandom, $urandom};
         4:       return 64'd0;
         default: return '1;
      endcase
   endfunction

   // ---------------- watchdog ----------------
   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // ---------------- stimulus ----------------
   initial begin
      int t;
      int base;
      int n;
      logic [1:0] k;
      string s;

      // Directed: "3-5\n\n1\n"
      do_reset();
      send_rec(KIND_RANGE, 64'd3, 64'd5, t);
      send_rec(KIND_SEP, 0, 0, t);
      send_rec(KIND_VALUE, 64'd1, 0, t);
      send_rec(KIND_END, 0, 0, t);
      wait_done(200);
      check("a_byte_count", 64'(byte_count), (NO_FINAL_NL != 0) ? 64'd6 : 64'd7);
      check("a_drained", 64'(exp_q.size()), 0);
      check("a_ready_after_end", 64'(in_ready), 0);
      check("a_proto_err", 64'(proto_err), 0);

      // Illegal records, zero value, maximum value with digit timing
      do_reset();
      send_rec(KIND_VALUE, 64'd5, 0, t);
      repeat (3) @(negedge clk);
      check("b_proto_err_first", 64'(proto_err), 1);
      send_rec(KIND_SEP, 0, 0, t);
      send_rec(KIND_RANGE, 64'd1, 64'd2, t);
      send_rec(KIND_VALUE, 64'd0, 0, t);
      send_rec(KIND_VALUE, '1, 0, t);
      arm_t = t;
      arm = 1'b1;
      send_rec(KIND_END, 0, 0, t);
      wait_done(200);
      check("b_proto_err", 64'(proto_err), 1);
      check("b_byte_count", 64'(byte_count), (NO_FINAL_NL != 0) ? 64'd23 : 64'd24);
      check("b_drained", 64'(exp_q.size()), 0);

      // Reset in the middle of a 20-digit EMIT
      do_reset();
      base = wr_seen;
      send_rec(KIND_SEP, 0, 0, t);
      send_rec(KIND_VALUE, '1, 0, t);
      n = 0;
      while (wr_seen < base + 7 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("c_digits_started", 64'(wr_seen >= base + 7), 1);
      #1;
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("c_we_after_rst", 64'(mem_we), 0);
      repeat (2) @(negedge clk);
      model_reset();
      rst = 1'b0;
      send_rec(KIND_RANGE, 64'd7, 64'd7, t);
      wait_idle(500);
      check("c_drained", 64'(exp_q.size()), 0);

      // Randomized 200-record stream
      do_reset();
      for (int i = 0; i < 199; i++) begin
         if (i < 60)       k = ($urandom_range(0, 9) == 0) ? KIND_VALUE : KIND_RANGE;
         else if (i == 60) k = KIND_SEP;
         else begin
            n = $urandom_range(0, 19);
            k = (n == 0) ? KIND_RANGE : (n == 1) ? KIND_SEP : KIND_VALUE;
         end
         send_rec(k, rand_val(), rand_val(), t);
      end
      send_rec(KIND_END, 0, 0, t);
      wait_done(200);
      check("r_byte_count", 64'(byte_count), 64'(model_count()));
      check("r_proto_err", 64'(proto_err), 64'(m_proto));
      check("r_overflow", 64'(overflow), 0);
      check("r_drained", 64'(exp_q.size()), 0);

      // 4-byte memory: "10-20\n" keeps only "10-2"
      do_reset();
      s_obs.delete();
      @(negedge clk);
      s_valid = 1'b1;
      s_kind  = KIND_RANGE;
      s_lo    = 64'd10;
      s_hi    = 64'd20;
      n = 0;
      while (!s_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      @(negedge clk);
      n = 0;
      while (!s_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("e_ready_return", 64'(s_ready), 1);
      check("e_overflow", 64'(s_overflow), 1);
      check("e_write_count", 64'(s_obs.size()), 4);
      s = "10-2";
      for (int i = 0; i < 4 && i < s_obs.size(); i++) begin
         check("e_addr", 64'(s_obs[i][AW+7:8]), 64'(i));
         check("e_data", 64'(s_obs[i][7:0]), 64'(s[i]));
      end
      s_valid = 1'b1;
      s_kind  = KIND_END;
      n = 0;
      while (!s_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      @(negedge clk);
      check("e_done", 64'(s_done), 1);
      check("e_byte_count", 64'(s_byte_count), 64'd6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
